mp3_board_sci: RTL and testbench



---
 rtl/mp3_board_sci_if.sv | 22 ++
 rtl/mp3_board_sci.sv | 174 +++++++++++++++++
 tb/tb_mp3_board_sci.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mp3_board_sci_if.sv
// Board-side control and SCI pin bundle for the VS10xx SCI master.
// The master modport is the controller's view of these pins.
interface mp3_board_sci_if;
   logic [7:0] i_ADDRESS;
   logic       i_SO;
   logic       i_WRITE_EN;
   logic       o_XCS;
   logic       o_SCK;
   logic       o_SI;
   logic       o_XRST;
   logic       o_DREQ;

   modport master (
      input  i_ADDRESS, i_SO, i_WRITE_EN,
      output o_XCS, o_SCK, o_SI, o_XRST, o_DREQ
   );

   modport slave (
      output i_ADDRESS, i_SO, i_WRITE_EN,
      input  o_XCS, o_SCK, o_SI, o_XRST, o_DREQ
   );
endinterface

// File: rtl/mp3_board_sci.sv
// SCI master for a VS10xx decoder: chip reset sequencing, then
// back-to-back 32-bit register write/read frames over SPI.
module mp3_board_sci #(
   parameter int CLK_DIV     = 4,
   parameter int RST_CYCLES  = 16,
   parameter int BOOT_CYCLES = 16,
   parameter int GAP_CYCLES  = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   mp3_board_sci_if.master bus,
   inout  wire  [15:0]     data
);

   typedef enum logic [2:0] {
      RST_HOLD, BOOT_WAIT, IDLE, LOAD, SHIFT, GAP
   } state_t;

   localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
   localparam logic [15:0] RST_M1  = 16'(RST_CYCLES - 1);
   localparam logic [15:0] BOOT_M1 = 16'(BOOT_CYCLES - 1);
   localparam logic [15:0] GAP_M1  = 16'(GAP_CYCLES - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [4:0]  bit_q, bit_d;
   logic [31:0] frame_q, frame_d;
   logic        wr_q, wr_d;
   logic [15:0] sh_q, sh_d;
   logic [15:0] rdata_q, rdata_d;
   logic        xcs_q, xcs_d;
   logic        sck_q, sck_d;
   logic        si_q, si_d;
   logic        xrst_q, xrst_d;
   logic        dreq_q, dreq_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      frame_d = frame_q;
      wr_d    = wr_q;
      sh_d    = sh_q;
      rdata_d = rdata_q;
      xcs_d   = xcs_q;
      sck_d   = sck_q;
      si_d    = si_q;
      xrst_d  = xrst_q;
      dreq_d  = dreq_q;
      case (state_q)
         RST_HOLD: begin
            if (cnt_q == RST_M1) begin
               state_d = BOOT_WAIT;
               cnt_d   = 16'd0;
               xrst_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         BOOT_WAIT: begin
            if (cnt_q == BOOT_M1) begin
               state_d = IDLE;
               cnt_d   = 16'd0;
               dreq_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         IDLE: begin
            state_d = LOAD;
            dreq_d  = 1'b0;
            xcs_d   = 1'b0;
            sck_d   = 1'b0;
            wr_d    = bus.i_WRITE_EN;
            frame_d = bus.i_WRITE_EN ?
                      {8'h02, bus.i_ADDRESS, data} :
                      {8'h03, bus.i_ADDRESS, 16'h0000};
            si_d    = frame_d[31];
            bit_d   = 5'd31;
            cnt_d   = 16'd0;
            sh_d    = 16'h0000;
         end
         LOAD: begin
            state_d = SHIFT;
            cnt_d   = 16'd0;
         end
         SHIFT: begin
            if (cnt_q != DIV_M1) begin
               cnt_d = cnt_q + 16'd1;
            end else begin
               cnt_d = 16'd0;
               if (!sck_q) begin
                  sck_d = 1'b1;
                  // Reply bits arrive in frame bits 15..0 only
                  if (!wr_q && !bit_q[4]) begin
                     sh_d = {sh_q[14:0], bus.i_SO};
                  end
               end else begin
                  sck_d = 1'b0;
                  if (bit_q == 5'd0) begin
                     state_d = GAP;
                     si_d    = 1'b0;
                     if (!wr_q) begin
                        rdata_d = sh_q;
                     end
                  end else begin
                     bit_d = bit_q - 5'd1;
                     si_d  = frame_q[bit_q - 5'd1];
                  end
               end
            end
         end
         GAP: begin
            if (!xcs_q) begin
               if (cnt_q == DIV_M1) begin
                  xcs_d = 1'b1;
                  cnt_d = 16'd0;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end else if (cnt_q == GAP_M1) begin
               state_d = IDLE;
               dreq_d  = 1'b1;
               cnt_d   = 16'd0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = RST_HOLD;
            cnt_d   = 16'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RST_HOLD;
         cnt_q   <= 16'd0;
         bit_q   <= 5'd31;
         frame_q <= 32'h0;
         wr_q    <= 1'b1;
         sh_q    <= 16'h0000;
         rdata_q <= 16'h0000;
         xcs_q   <= 1'b1;
         sck_q   <= 1'b0;
         si_q    <= 1'b0;
         xrst_q  <= 1'b0;
         dreq_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         frame_q <= frame_d;
         wr_q    <= wr_d;
         sh_q    <= sh_d;
         rdata_q <= rdata_d;
         xcs_q   <= xcs_d;
         sck_q   <= sck_d;
         si_q    <= si_d;
         xrst_q  <= xrst_d;
         dreq_q  <= dreq_d;
      end
   end

   assign bus.o_XCS  = xcs_q;
   assign bus.o_SCK  = sck_q;
   assign bus.o_SI   = si_q;
   assign bus.o_XRST = xrst_q;
   assign bus.o_DREQ = dreq_q;

   assign data = bus.i_WRITE_EN ? 16'hzzzz : rdata_q;

endmodule

// File: tb/tb_mp3_board_sci.sv
// Bench for mp3_board_sci: directed frames with a queue of expected
// frames checked by an independent pin monitor and chip model.
module tb_mp3_board_sci;

   typedef struct packed {
      logic        we;
      logic [7:0]  addr;
      logic [15:0] wd;
      logic [15:0] so;
      logic [31:0] frame;
   } vec_t;

   typedef struct packed {
      logic        rd;
      logic [15:0] so;
      logic [31:0] frame;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        drv_en;
   logic [15:0] drv_val;
   wire  [15:0] data;

   int n_chk  = 0;
   int n_fail = 0;

   vec_t vecs [8];
   exp_t q [$];
   exp_t e;

   int          mon_rc;
   int          mon_w;
   int          idx;
   logic [31:0] mon_bits;
   logic        in_frame;
   logic        prev_sck;
   logic [15:0] exp_rdata;

   mp3_board_sci_if bus ();

   mp3_board_sci dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .data  (data)
   );

   assign data = drv_en ? drv_val : 16'hzzzz;

   always #5 clk = ~clk;

   function automatic void chk(string nm, logic [31:0] act,
                               logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   // Pin monitor plus VS10xx reply model
   always @(negedge clk) begin
      if (!rst_n) begin
         if (in_frame && q.size() > 0) void'(q.pop_front());
         in_frame  = 1'b0;
         prev_sck  = 1'b0;
         mon_rc    = 0;
         mon_w     = 0;
         mon_bits  = 32'h0;
         exp_rdata = 16'h0000;
         bus.i_SO  = 1'b0;
      end else begin
         if (!in_frame && !bus.o_XCS) begin
            in_frame = 1'b1;
            mon_w    = 0;
            mon_rc   = 0;
            mon_bits = 32'h0;
         end
         if (bus.o_XCS) chk("si_idle", bus.o_SI, 1'b0);
         if (in_frame) begin
            if (!bus.o_XCS) mon_w++;
            if (bus.o_SCK && !prev_sck) begin
               mon_bits = {mon_bits[30:0], bus.o_SI};
               mon_rc++;
            end
            if (bus.o_XCS) begin
               in_frame = 1'b0;
               if (q.size() == 0) begin
                  chk("frame_unexpected", 32'd1, 32'd0);
               end else begin
                  e = q.pop_front();
                  chk("frame_bits", mon_bits, e.frame);
                  chk("sck_rises", mon_rc, 32);
                  chk("xcs_width", mon_w, 261);
                  if (e.rd) exp_rdata = e.so;
                  if (!bus.i_WRITE_EN) chk("rd_bus", data, exp_rdata);
                  else chk("wr_bus", data, drv_val);
               end
               mon_rc = 0;
            end
         end
         prev_sck = bus.o_SCK;
         idx = 31 - mon_rc;
         if (in_frame && q.size() > 0 && mon_rc >= 16 && mon_rc < 32)
            bus.i_SO = q[0].so[idx];
         else
            bus.i_SO = 1'b0;
      end
   end

   task automatic apply(input vec_t v);
      bus.i_WRITE_EN = v.we;
      bus.i_ADDRESS  = v.addr;
      drv_val        = v.wd;
      drv_en         = v.we;
   endtask

   task automatic push(input vec_t v);
      q.push_back('{rd: !v.we, so: v.so, frame: v.frame});
   endtask

   task automatic reset_outs(input string tag);
      chk({tag, "_xcs"}, bus.o_XCS, 1'b1);
      chk({tag, "_sck"}, bus.o_SCK, 1'b0);
      chk({tag, "_si"}, bus.o_SI, 1'b0);
      chk({tag, "_xrst"}, bus.o_XRST, 1'b0);
      chk({tag, "_dreq"}, bus.o_DREQ, 1'b0);
   endtask

   task automatic release_check();
      int k;
      rst_n = 1'b1;
      k = 0;
      while (!bus.o_XRST && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("xrst_rise", k, 16);
      k = 0;
      while (!bus.o_DREQ && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("dreq_first", k, 16);
   endtask

   task automatic wait_dreq();
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!bus.o_DREQ && k < 400);
      chk("dreq_wait", bus.o_DREQ, 1'b1);
   endtask

   initial begin
      int k;
      vecs[0] = '{1'b1, 8'h0D, 16'h00F0, 16'h0000, 32'h020D00F0};
      vecs[1] = '{1'b1, 8'h05, 16'h1234, 16'h0000, 32'h02051234};
      vecs[2] = '{1'b0, 8'h0B, 16'h0000, 16'hA5C3, 32'h030B0000};
      vecs[3] = '{1'b0, 8'h0B, 16'h0000, 16'h3C5A, 32'h030B0000};
      vecs[4] = '{1'b1, 8'h80, 16'hFFFF, 16'h0000, 32'h0280FFFF};
      vecs[5] = '{1'b0, 8'hFF, 16'h0000, 16'h0001, 32'h03FF0000};
      vecs[6] = '{1'b1, 8'h0D, 16'h00F0, 16'h0000, 32'h020D00F0};
      vecs[7] = '{1'b0, 8'h0B, 16'h0000, 16'h0F0F, 32'h030B0000};

      rst_n = 1'b0;
      apply(vecs[0]);
      repeat (20) @(negedge clk);
      reset_outs("por");
      release_check();

      for (int i = 0; i < 7; i++) begin
         if (i > 0) wait_dreq();
         push(vecs[i]);
         if (i == 6) begin
            k = 0;
            while (mon_rc < 22 && k < 400) begin
               @(negedge clk);
               k++;
            end
            chk("abort_bit10", mon_rc, 22);
            #2 rst_n = 1'b0;
            #1 reset_outs("abort");
            apply(vecs[7]);
            #1 chk("rst_rdata", data, 16'h0000);
         end else begin
            @(posedge clk);
            repeat (40) @(posedge clk);
            #1;
            if (i == 3) begin
               bus.i_WRITE_EN = 1'b1;
               drv_val = 16'h00F0;
               drv_en  = 1'b1;
               #1 chk("dir_wr1", data, 16'h00F0);
               bus.i_WRITE_EN = 1'b0;
               drv_en  = 1'b0;
               #1 chk("dir_rd", data, 16'hA5C3);
               bus.i_WRITE_EN = 1'b1;
               drv_en  = 1'b1;
               #1 chk("dir_wr2", data, 16'h00F0);
            end
            apply(vecs[i + 1]);
         end
      end

      repeat (20) @(negedge clk);
      reset_outs("rerst");
      release_check();
      push(vecs[7]);
      k = 0;
      while (q.size() != 0 && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("final_drain", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
